// File: rtl/quad_pkg.sv
// quad_pkg: shared definitions for the quadrature decoder.
//   - Gray code constants for the four AB phase states
//   - Direction encodings for the mode output
//   - Decoder FSM state type
//   - grayNext(): forward successor of an AB phase state
package quad_pkg;

  localparam logic [1:0] GRAY_00 = 2'b00;
  localparam logic [1:0] GRAY_01 = 2'b01;
  localparam logic [1:0] GRAY_11 = 2'b11;
  localparam logic [1:0] GRAY_10 = 2'b10;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } quad_state_t;

  // Forward direction walks 00 -> 01 -> 11 -> 10 -> 00 ({a,b}).
  function automatic logic [1:0] grayNext(input logic [1:0] ab);
    case (ab)
      GRAY_00: grayNext = GRAY_01;
      GRAY_01: grayNext = GRAY_11;
      GRAY_11: grayNext = GRAY_10;
      default: grayNext = GRAY_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// quad_decoder_if: bus between the quadrature decoder and its user.
//   ld        load strobe, count_in  load value (N+1 bits, [0:N])
//   a_in/b_in raw asynchronous quadrature phases
//   count     registered position, mode  last direction (0 up, 1 down)
//   step/ovf/err  one-cycle event pulses
// master modport drives the inputs, slave modport is the decoder side.
interface quad_decoder_if #(parameter int N = 7);

  logic       ld;
  logic [0:N] count_in;
  logic       a_in;
  logic       b_in;
  logic [0:N] count;
  logic [1:0] mode;
  logic       step;
  logic       ovf;
  logic       err;

  modport master (
    output ld, count_in, a_in, b_in,
    input  count, mode, step, ovf, err
  );

  modport slave (
    input  ld, count_in, a_in, b_in,
    output count, mode, step, ovf, err
  );

endinterface

// File: rtl/quad_sync.sv
// quad_sync: brings the asynchronous a/b phases into the clock domain.
// Ports:
//   clock    sole clock
//   clear    synchronous active-high reset
//   i_a/i_b  raw asynchronous phases
//   o_ab     clean {a,b} sample
//   o_valid  high once o_ab carries a real post-reset sample
// Optional macro QUAD_FILTER_EN adds a 2-sample agreement filter that
// rejects single-cycle glitches (two extra cycles of latency).
module quad_sync (
  input  logic       clock,
  input  logic       clear,
  input  logic       i_a,
  input  logic       i_b,
  output logic [1:0] o_ab,
  output logic       o_valid
);

  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic       r_v1;
  logic       r_v2;

  // The valid bits travel alongside the data so the reset value of the
  // flops is never mistaken for a real input sample.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_s1 <= 2'b00;
      r_s2 <= 2'b00;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_s1 <= {i_a, i_b};
      r_s2 <= r_s1;
      r_v1 <= 1'b1;
      r_v2 <= r_v1;
    end
  end

`ifdef QUAD_FILTER_EN
  logic [1:0] r_s3;
  logic       r_v3;
  logic [1:0] r_clean;
  logic       r_cleanValid;

  // A new value is only taken once two consecutive synchronized samples agree.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_s3         <= 2'b00;
      r_v3         <= 1'b0;
      r_clean      <= 2'b00;
      r_cleanValid <= 1'b0;
    end else begin
      r_s3 <= r_s2;
      r_v3 <= r_v2;
      if (r_v3 && (r_s2 == r_s3)) begin
        r_clean      <= r_s2;
        r_cleanValid <= 1'b1;
      end
    end
  end

  assign o_ab    = r_clean;
  assign o_valid = r_cleanValid;
`else
  assign o_ab    = r_s2;
  assign o_valid = r_v2;
`endif

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature decoder with an N+1 bit wrapping position counter.
// Ports:
//   clock  sole clock, rising edge
//   clear  synchronous active-high reset
//   bus    quad_decoder_if.slave (ld, count_in, a_in, b_in in;
//          count, mode, step, ovf, err out)
// Build option: QUAD_FILTER_EN (glitch filter inside quad_sync).
module quad_decoder
  import quad_pkg::*;
#(
  parameter int N = 7
) (
  input logic           clock,
  input logic           clear,
  quad_decoder_if.slave bus
);

  localparam logic [0:N] COUNT_ZERO = '0;
  localparam logic [0:N] COUNT_ONES = '1;
  localparam logic [0:N] COUNT_ONE  = {{N{1'b0}}, 1'b1};

  logic [1:0]  w_ab;
  logic        w_valid;

  quad_state_t r_state;
  quad_state_t w_nextState;
  logic [1:0]  r_prevAb;
  logic [1:0]  w_nextPrevAb;
  logic [0:N]  r_count;
  logic [0:N]  w_nextCount;
  logic [1:0]  r_mode;
  logic [1:0]  w_nextMode;
  logic        r_step;
  logic        w_nextStep;
  logic        r_ovf;
  logic        w_nextOvf;
  logic        r_err;
  logic        w_nextErr;

  quad_sync u_sync (
    .clock   (clock),
    .clear   (clear),
    .i_a     (bus.a_in),
    .i_b     (bus.b_in),
    .o_ab    (w_ab),
    .o_valid (w_valid)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state  <= UNPRIMED;
      r_prevAb <= GRAY_00;
      r_count  <= COUNT_ZERO;
      r_mode   <= MODE_UP;
      r_step   <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_prevAb <= w_nextPrevAb;
      r_count  <= w_nextCount;
      r_mode   <= w_nextMode;
      r_step   <= w_nextStep;
      r_ovf    <= w_nextOvf;
      r_err    <= w_nextErr;
    end
  end

  // UNPRIMED waits for the first real sample and only records it; TRACK
  // compares every sample against the previous one. prevAb always follows
  // the sample, including on err and ld, so nothing is counted twice.
  always_comb begin
    w_nextState  = r_state;
    w_nextPrevAb = r_prevAb;
    w_nextCount  = r_count;
    w_nextMode   = r_mode;
    w_nextStep   = 1'b0;
    w_nextOvf    = 1'b0;
    w_nextErr    = 1'b0;

    case (r_state)
      UNPRIMED: begin
        if (w_valid) begin
          w_nextPrevAb = w_ab;
          w_nextState  = TRACK;
        end
      end
      TRACK: begin
        w_nextPrevAb = w_ab;
        if (w_ab == grayNext(r_prevAb)) begin
          w_nextCount = r_count + COUNT_ONE;
          w_nextMode  = MODE_UP;
          w_nextStep  = 1'b1;
          w_nextOvf   = (r_count == COUNT_ONES);
        end else if (grayNext(w_ab) == r_prevAb) begin
          w_nextCount = r_count - COUNT_ONE;
          w_nextMode  = MODE_DOWN;
          w_nextStep  = 1'b1;
          w_nextOvf   = (r_count == COUNT_ZERO);
        end else if (w_ab != r_prevAb) begin
          w_nextErr = 1'b1;
        end
      end
      default: w_nextState = UNPRIMED;
    endcase

    // A load overrides whatever the decode produced this cycle.
    if (bus.ld) begin
      w_nextCount = bus.count_in;
      w_nextMode  = r_mode;
      w_nextStep  = 1'b0;
      w_nextOvf   = 1'b0;
      w_nextErr   = 1'b0;
    end
  end

  assign bus.count = r_count;
  assign bus.mode  = r_mode;
  assign bus.step  = r_step;
  assign bus.ovf   = r_ovf;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: table-driven self-checking bench for quad_decoder (N=7).
// Build option: QUAD_FILTER_EN selects the filtered-latency expectations
// and the glitch sequence.
module tb_quad_decoder;

`ifdef QUAD_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int NUM_VEC = 14;

  typedef struct {
    logic       doLoad;
    logic [7:0] loadVal;
    logic [1:0] ab;
    logic [7:0] expCount;
    logic [1:0] expMode;
    logic       expStep;
    logic       expOvf;
    logic       expErr;
  } vec_t;

  logic clock;
  logic clear;
  int   assertCount;
  int   failCount;
  vec_t vecs [NUM_VEC];
  logic [7:0] prevCount;

  quad_decoder_if #(.N(7)) bus ();

  quad_decoder #(.N(7)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s[%0d]: got %0h, expected %0h", name, idx, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.doLoad) begin
      bus.ld       = 1'b1;
      bus.count_in = v.loadVal;
    end else begin
      bus.a_in = v.ab[1];
      bus.b_in = v.ab[0];
    end
  endtask

  task automatic watchQuiet(input int cycles, input string name);
    logic saw;
    saw = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clock);
      #1;
      if (bus.step || bus.ovf || bus.err) saw = 1'b1;
    end
    checkOutput(name, 0, {31'd0, saw}, 32'd0);
  endtask

  task automatic driveAb(input logic [1:0] ab);
    bus.a_in = ab[1];
    bus.b_in = ab[0];
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;

    //               load  loadVal ab     count  mode   stp   ovf   err
    vecs[0]  = '{1'b0, 8'h00, 2'b01, 8'h01, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 2'b11, 8'h02, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 2'b10, 8'h03, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 2'b00, 8'h04, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h00, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 2'b10, 8'hFF, 2'b01, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 8'hFF, 2'b10, 8'hFF, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 2'b00, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 2'b11, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 2'b10, 8'h01, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 2'b11, 8'h00, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 2'b01, 8'hFF, 2'b01, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 2'b10, 8'hFF, 2'b01, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 2'b10, 8'hFF, 2'b01, 1'b0, 1'b0, 1'b0};

    // Reset state
    clear        = 1'b1;
    bus.ld       = 1'b0;
    bus.count_in = 8'h00;
    driveAb(2'b00);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_count", 0, {24'd0, bus.count}, 32'h00);
    checkOutput("reset_mode",  0, {30'd0, bus.mode},  32'h0);
    checkOutput("reset_step",  0, {31'd0, bus.step},  32'h0);
    checkOutput("reset_ovf",   0, {31'd0, bus.ovf},   32'h0);
    checkOutput("reset_err",   0, {31'd0, bus.err},   32'h0);
    clear = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    checkOutput("prime_count", 0, {24'd0, bus.count}, 32'h00);

    // Table-driven vectors
    prevCount = 8'h00;
    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].doLoad) begin
        @(posedge clock);
        #1;
        bus.ld = 1'b0;
      end else begin
        repeat (LAT) @(posedge clock);
        #1;
        checkOutput("early_count", i, {24'd0, bus.count}, {24'd0, prevCount});
        checkOutput("early_step",  i, {31'd0, bus.step},  32'h0);
        @(posedge clock);
        #1;
      end
      checkOutput("count", i, {24'd0, bus.count}, {24'd0, vecs[i].expCount});
      checkOutput("mode",  i, {30'd0, bus.mode},  {30'd0, vecs[i].expMode});
      checkOutput("step",  i, {31'd0, bus.step},  {31'd0, vecs[i].expStep});
      checkOutput("ovf",   i, {31'd0, bus.ovf},   {31'd0, vecs[i].expOvf});
      checkOutput("err",   i, {31'd0, bus.err},   {31'd0, vecs[i].expErr});
      @(posedge clock);
      #1;
      checkOutput("pulse_end", i, {29'd0, bus.step, bus.ovf, bus.err}, 32'h0);
      checkOutput("count_hold", i, {24'd0, bus.count}, {24'd0, vecs[i].expCount});
      repeat (4) @(posedge clock);
      #1;
      prevCount = vecs[i].expCount;
    end

    // Load collides with a decoded forward wrap (FF -> 00): load wins,
    // and the step is neither applied nor replayed afterwards.
    driveAb(2'b00);
    repeat (LAT) @(posedge clock);
    #1;
    bus.ld       = 1'b1;
    bus.count_in = 8'h50;
    @(posedge clock);
    #1;
    bus.ld = 1'b0;
    checkOutput("ld_collide_count", 0, {24'd0, bus.count}, 32'h50);
    checkOutput("ld_collide_pulse", 0, {29'd0, bus.step, bus.ovf, bus.err}, 32'h0);
    watchQuiet(8, "ld_no_replay");
    checkOutput("ld_after_count", 0, {24'd0, bus.count}, 32'h50);
    driveAb(2'b01);
    repeat (LAT + 1) @(posedge clock);
    #1;
    checkOutput("ld_next_count", 0, {24'd0, bus.count}, 32'h51);
    checkOutput("ld_next_step",  0, {31'd0, bus.step},  32'h1);

    // Clear lands on the edge a transition (01 -> 11) reaches decode.
    repeat (4) @(posedge clock);
    #1;
    driveAb(2'b11);
    repeat (LAT - 1) @(posedge clock);
    #1;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    checkOutput("clr_count", 0, {24'd0, bus.count}, 32'h00);
    checkOutput("clr_step",  0, {31'd0, bus.step},  32'h0);
    checkOutput("clr_mode",  0, {30'd0, bus.mode},  32'h0);
    watchQuiet(10, "clr_prime_quiet");
    checkOutput("clr_prime_count", 0, {24'd0, bus.count}, 32'h00);
    // Priming must have captured 11, so 11 -> 10 is one forward step.
    driveAb(2'b10);
    repeat (LAT + 1) @(posedge clock);
    #1;
    checkOutput("clr_fwd_count", 0, {24'd0, bus.count}, 32'h01);
    checkOutput("clr_fwd_mode",  0, {30'd0, bus.mode},  32'h0);
    checkOutput("clr_fwd_step",  0, {31'd0, bus.step},  32'h1);

`ifdef QUAD_FILTER_EN
    // One-cycle glitch on a_in (10 -> 00 -> 10) is swallowed by the filter.
    repeat (4) @(posedge clock);
    #1;
    bus.a_in = 1'b0;
    @(posedge clock);
    #1;
    bus.a_in = 1'b1;
    watchQuiet(10, "glitch_quiet");
    checkOutput("glitch_count", 0, {24'd0, bus.count}, 32'h01);
    driveAb(2'b00);
    repeat (LAT) @(posedge clock);
    #1;
    checkOutput("filt_early_count", 0, {24'd0, bus.count}, 32'h01);
    @(posedge clock);
    #1;
    checkOutput("filt_count", 0, {24'd0, bus.count}, 32'h02);
    checkOutput("filt_step",  0, {31'd0, bus.step},  32'h1);
`endif

    repeat (4) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
